// File: rtl/weight_addr_pkg.sv
// Shared types and sizing helpers for the weight tile address generator.
// Latency: n/a (package only).
// Backpressure: n/a.
package weight_addr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } wa_state_e;

    localparam int unsigned DEF_ADDR_W = 16;
    localparam int unsigned DEF_DIM_W  = 12;
    localparam int unsigned DEF_TILE_R = 8;
    localparam int unsigned DEF_TILE_C = 8;
    localparam int unsigned DEF_PASS_W = 10;

    // Width of a counter that runs 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wa_wrap_counter.sv
// Enabled up-counter with a programmable terminal value and a wrap pulse.
// Latency: count updates 1 cycle after en; wrap is combinational (en && cnt==max).
// Backpressure: none; the parent gates en with its handshake.
module wa_wrap_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] max,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    assign wrap = en && (cnt == max);

    // Count on enable, return to zero after the terminal value; clr restarts a run.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/weight_tile_addr_gen.sv
// Tiled weight-SRAM address walker (row_tile, pass, col_tile, tr, tc) with pad flags; WADDR_TRANSPOSE_EN adds column-major addressing.
// Latency: first beat valid 1 cycle after an accepted cfg_start; 1 beat per clock thereafter.
// Backpressure: advances only on o_valid && o_ready; beat outputs held stable while stalled.
module weight_tile_addr_gen
    import weight_addr_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DIM_W  = DEF_DIM_W,
    parameter int TILE_R = DEF_TILE_R,
    parameter int TILE_C = DEF_TILE_C,
    parameter int PASS_W = DEF_PASS_W
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cfg_start,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [DIM_W-1:0]  cfg_rows,
    input  logic [DIM_W-1:0]  cfg_cols,
    input  logic [PASS_W-1:0] cfg_passes,
`ifdef WADDR_TRANSPOSE_EN
    input  logic              cfg_transpose,
`endif
    output logic              busy,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_pad,
    output logic              o_tile_last,
    output logic              o_done
);

    localparam int TRW = cnt_w(TILE_R);
    localparam int TCW = cnt_w(TILE_C);
    localparam int CW  = DIM_W + 1;   // row/col coordinates overshoot K/W inside edge tiles
    localparam logic [TRW-1:0] TR_MAX = TRW'(TILE_R - 1);
    localparam logic [TCW-1:0] TC_MAX = TCW'(TILE_C - 1);

    wa_state_e st_q, st_d;

    logic [ADDR_W-1:0] base_q;
    logic [DIM_W-1:0]  rows_q, cols_q, ctmax_q, rtmax_q;
    logic [PASS_W-1:0] psmax_q;
    logic [CW-1:0]     ncol_t, nrow_t;
    logic              start_ok, zero_dim, adv, fin;

    logic [TCW-1:0]    tc;
    logic [TRW-1:0]    tr;
    logic [DIM_W-1:0]  ct_cnt, rt_cnt;
    logic [PASS_W-1:0] ps_cnt;
    logic              tc_w, tr_w, ct_w, ps_w, rt_w;
    logic              unused_cnt;

    logic [CW-1:0]     r0, c0, r, c;
    logic [ADDR_W-1:0] rbase0, rbase, cols_a, addr;
    logic              pad;

    assign start_ok = cfg_start && (st_q == IDLE);
    assign zero_dim = (cfg_rows == '0) || (cfg_cols == '0);
    assign adv      = o_valid && o_ready;
    assign fin      = rt_w;
    assign ncol_t   = ({1'b0, cfg_cols} + CW'(TILE_C - 1)) / CW'(TILE_C);
    assign nrow_t   = ({1'b0, cfg_rows} + CW'(TILE_R - 1)) / CW'(TILE_R);
    assign unused_cnt = ^{ct_cnt, ps_cnt, rt_cnt};

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) st_q <= IDLE;
        else       st_q <= st_d;
    end

    // Next state: empty matrices skip straight to DONE; starts are ignored once running.
    always_comb begin
        st_d = st_q;
        case (st_q)
            IDLE:    if (cfg_start) st_d = zero_dim ? DONE : RUN;
            RUN:     if (fin) st_d = DONE;
            DONE:    st_d = IDLE;
            default: st_d = IDLE;
        endcase
    end

    // Latch the job and precompute terminal tile/pass indices so the beat path only compares.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            base_q  <= '0;
            rows_q  <= '0;
            cols_q  <= '0;
            ctmax_q <= '0;
            rtmax_q <= '0;
            psmax_q <= '0;
        end else if (start_ok) begin
            base_q  <= cfg_base;
            rows_q  <= cfg_rows;
            cols_q  <= cfg_cols;
            ctmax_q <= DIM_W'(ncol_t - CW'(1));
            rtmax_q <= DIM_W'(nrow_t - CW'(1));
            psmax_q <= (cfg_passes == '0) ? '0 : cfg_passes - PASS_W'(1);
        end
    end

    // Loop nest, innermost first; each level is enabled by the wrap of the one inside it.
    wa_wrap_counter #(.W(TCW))    u_tc (.clk(clk), .rstn(rstn), .clr(start_ok), .en(adv),
                                        .max(TC_MAX),  .cnt(tc),     .wrap(tc_w));
    wa_wrap_counter #(.W(TRW))    u_tr (.clk(clk), .rstn(rstn), .clr(start_ok), .en(tc_w),
                                        .max(TR_MAX),  .cnt(tr),     .wrap(tr_w));
    wa_wrap_counter #(.W(DIM_W))  u_ct (.clk(clk), .rstn(rstn), .clr(start_ok), .en(tr_w),
                                        .max(ctmax_q), .cnt(ct_cnt), .wrap(ct_w));
    wa_wrap_counter #(.W(PASS_W)) u_ps (.clk(clk), .rstn(rstn), .clr(start_ok), .en(ct_w),
                                        .max(psmax_q), .cnt(ps_cnt), .wrap(ps_w));
    wa_wrap_counter #(.W(DIM_W))  u_rt (.clk(clk), .rstn(rstn), .clr(start_ok), .en(ps_w),
                                        .max(rtmax_q), .cnt(rt_cnt), .wrap(rt_w));

    assign cols_a = ADDR_W'(cols_q);
    assign r      = r0 + CW'(tr);
    assign c      = c0 + CW'(tc);
    assign pad    = (r >= {1'b0, rows_q}) || (c >= {1'b0, cols_q});

    // Tile origins and row base address, stepped by pitch adds instead of multiplies.
    // rbase tracks base + r*W; rbase0 is the same at the first row of the current row tile.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r0     <= '0;
            c0     <= '0;
            rbase0 <= '0;
            rbase  <= '0;
        end else if (start_ok) begin
            r0     <= '0;
            c0     <= '0;
            rbase0 <= cfg_base;
            rbase  <= cfg_base;
        end else if (adv && tc_w) begin
            if (tr_w) begin
                if (ps_w) begin
                    // last row of a row tile steps straight onto the first row of the next
                    r0     <= r0 + CW'(TILE_R);
                    rbase0 <= rbase + cols_a;
                    rbase  <= rbase + cols_a;
                end else begin
                    rbase  <= rbase0;
                end
                c0 <= ct_w ? '0 : c0 + CW'(TILE_C);
            end else begin
                rbase <= rbase + cols_a;
            end
        end
    end

`ifdef WADDR_TRANSPOSE_EN
    logic              tp_q;
    logic [ADDR_W-1:0] cbase0, cbase, rows_a;

    assign rows_a = ADDR_W'(rows_q);

    // Column-major mirror: cbase tracks base + c*K, cbase0 the same at the tile's first column.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tp_q   <= 1'b0;
            cbase0 <= '0;
            cbase  <= '0;
        end else if (start_ok) begin
            tp_q   <= cfg_transpose;
            cbase0 <= cfg_base;
            cbase  <= cfg_base;
        end else if (adv) begin
            if (tc_w) begin
                if (tr_w) begin
                    if (ct_w) begin
                        cbase0 <= base_q;
                        cbase  <= base_q;
                    end else begin
                        cbase0 <= cbase + rows_a;
                        cbase  <= cbase + rows_a;
                    end
                end else begin
                    cbase <= cbase0;
                end
            end else begin
                cbase <= cbase + rows_a;
            end
        end
    end

    assign addr = tp_q ? cbase + ADDR_W'(r) : rbase + ADDR_W'(c);
`else
    assign addr = rbase + ADDR_W'(c);
`endif

    // Stream and status outputs; everything beat-related is gated by o_valid so idle/reset reads 0.
    always_comb begin
        o_valid     = (st_q == RUN);
        busy        = (st_q != IDLE);
        o_done      = (st_q == DONE);
        o_pad       = o_valid && pad;
        o_addr      = (o_valid && !pad) ? addr : '0;
        o_tile_last = o_valid && (tc == TC_MAX) && (tr == TR_MAX);
    end

endmodule

// File: tb/tb_weight_tile_addr_gen.sv
module tb_weight_tile_addr_gen;

    localparam int TR = 8;
    localparam int TC = 8;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cfg_start = 1'b0;
    logic [15:0] cfg_base = '0;
    logic [11:0] cfg_rows = '0;
    logic [11:0] cfg_cols = '0;
    logic [9:0]  cfg_passes = '0;
`ifdef WADDR_TRANSPOSE_EN
    logic        cfg_transpose = 1'b0;
`endif
    logic        busy, o_valid, o_pad, o_tile_last, o_done;
    logic        o_ready = 1'b0;
    logic [15:0] o_addr;

    weight_tile_addr_gen dut (
        .clk(clk), .rstn(rstn), .cfg_start(cfg_start), .cfg_base(cfg_base),
        .cfg_rows(cfg_rows), .cfg_cols(cfg_cols), .cfg_passes(cfg_passes),
`ifdef WADDR_TRANSPOSE_EN
        .cfg_transpose(cfg_transpose),
`endif
        .busy(busy), .o_valid(o_valid), .o_ready(o_ready), .o_addr(o_addr),
        .o_pad(o_pad), .o_tile_last(o_tile_last), .o_done(o_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] addr;
        logic        pad;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_e, held;
    int    vectors = 0, miscompares = 0;
    int    beats_seen = 0, unpad_seen = 0, done_seen = 0;
    bit    rand_ready = 1'b0;
    bit    stall_pend = 1'b0;

    task automatic check(input string name, input int unsigned act, input int unsigned req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: plain nested loops over the tiled walk, straight from the addressing rules.
    task automatic build_model(input logic [15:0] base, input int rows, input int cols,
                               input int passes, input bit tp);
        int nr, nc, np, r, c;
        logic [31:0] a;
        beat_t b;
        nr = (rows + TR - 1) / TR;
        nc = (cols + TC - 1) / TC;
        np = (passes == 0) ? 1 : passes;
        for (int rt = 0; rt < nr; rt++)
            for (int p = 0; p < np; p++)
                for (int ct = 0; ct < nc; ct++)
                    for (int tr = 0; tr < TR; tr++)
                        for (int tc = 0; tc < TC; tc++) begin
                            r = rt * TR + tr;
                            c = ct * TC + tc;
                            b.pad  = (r >= rows) || (c >= cols);
                            b.last = (tr == TR - 1) && (tc == TC - 1);
                            a = tp ? (32'(base) + 32'(c * rows + r)) : (32'(base) + 32'(r * cols + c));
                            b.addr = b.pad ? 16'h0 : a[15:0];
                            exp_q.push_back(b);
                        end
    endtask

    // Consumer readiness changes just after each rising edge.
    always begin
        @(posedge clk);
        #1;
        o_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: pops the scoreboard on every handshake and checks stall stability.
    always @(negedge clk) begin
        if (!rstn) begin
            stall_pend = 1'b0;
        end else begin
            if (stall_pend) begin
                check("stall_valid", o_valid, 1);
                check("stall_addr", o_addr, held.addr);
                check("stall_pad", o_pad, held.pad);
                check("stall_last", o_tile_last, held.last);
            end
            stall_pend = 1'b0;
            if (o_valid) begin
                if (o_ready) begin
                    if (exp_q.size() == 0) begin
                        check("extra_beat", 1, 0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("addr", o_addr, mon_e.addr);
                        check("pad", o_pad, mon_e.pad);
                        check("tile_last", o_tile_last, mon_e.last);
                    end
                    beats_seen++;
                    if (!o_pad) unpad_seen++;
                end else begin
                    stall_pend = 1'b1;
                    held = {o_addr, o_pad, o_tile_last};
                end
            end
            if (o_done) done_seen++;
        end
    end

    task automatic drive_start(input logic [15:0] base, input int rows, input int cols,
                               input int passes, input bit tp);
        @(posedge clk);
        #1;
        cfg_base   = base;
        cfg_rows   = 12'(rows);
        cfg_cols   = 12'(cols);
        cfg_passes = 10'(passes);
`ifdef WADDR_TRANSPOSE_EN
        cfg_transpose = tp;
`endif
        cfg_start  = 1'b1;
        @(posedge clk);
        #1;
        cfg_start  = 1'b0;
    endtask

    task automatic run_cfg(input logic [15:0] base, input int rows, input int cols, input int passes,
                           input bit tp, input bit rr, input bit glitch,
                           input int exp_beats, input int exp_unpad);
        int b0, u0, d0;
        bit got;
        rand_ready = rr;
        build_model(base, rows, cols, passes, tp);
        b0 = beats_seen;
        u0 = unpad_seen;
        d0 = done_seen;
        drive_start(base, rows, cols, passes, tp);
        got = 1'b0;
        for (int i = 0; i < 20000 && !got; i++) begin
            @(negedge clk);
            #1;
            if (glitch && i == 20) begin
                cfg_start = 1'b1;
                cfg_cols  = 12'd3;
                cfg_base  = 16'hBEEF;
            end
            if (glitch && i == 21) cfg_start = 1'b0;
            if (done_seen != d0) got = 1'b1;
        end
        cfg_start = 1'b0;
        check("done_seen", got, 1);
        repeat (3) @(negedge clk);
        #1;
        check("done_once", done_seen - d0, 1);
        check("queue_drained", exp_q.size(), 0);
        check("busy_after", busy, 0);
        if (exp_beats >= 0) begin
            check("beat_count", beats_seen - b0, exp_beats);
            check("unpad_count", unpad_seen - u0, exp_unpad);
        end
        exp_q.delete();
    endtask

    initial begin
        int d0, b0, lat, rows, cols;
        bit got;

        #12;
        check("rst_valid", o_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_addr", o_addr, 0);
        check("rst_done", o_done, 0);
        #11;
        rstn = 1'b1;

        // Basic walk, replays, single tile, backpressure with an ignored restart.
        run_cfg(16'h0100, 10, 12, 1, 1'b0, 1'b0, 1'b0, 256, 120);
        run_cfg(16'h0100, 10, 12, 2, 1'b0, 1'b0, 1'b0, 512, 240);
        run_cfg(16'h0100, 8, 8, 1, 1'b0, 1'b0, 1'b0, 64, 64);
        run_cfg(16'h0100, 10, 12, 1, 1'b0, 1'b1, 1'b1, 256, 120);
        run_cfg(16'hFFF0, 9, 5, 0, 1'b0, 1'b1, 1'b0, 128, 45);

        // Empty matrix: no beats, o_done right after start.
        rand_ready = 1'b0;
        d0 = done_seen;
        b0 = beats_seen;
        drive_start(16'h0100, 0, 5, 1, 1'b0);
        lat = 0;
        got = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            #1;
            if (o_done && !got) begin
                got = 1'b1;
                lat = i;
            end
        end
        check("rows0_done_lat", lat, 1);
        check("rows0_done_cnt", done_seen - d0, 1);
        check("rows0_beats", beats_seen - b0, 0);

        // Reset mid-run aborts; a fresh start reproduces the walk from beat 0.
        rand_ready = 1'b1;
        build_model(16'h0100, 10, 12, 1, 1'b0);
        d0 = done_seen;
        b0 = beats_seen;
        drive_start(16'h0100, 10, 12, 1, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clk);
            if (beats_seen - b0 >= 40) got = 1'b1;
        end
        check("rst_wait", got, 1);
        #2;
        rstn = 1'b0;
        #1;
        check("arst_valid", o_valid, 0);
        check("arst_addr", o_addr, 0);
        check("arst_pad", o_pad, 0);
        check("arst_last", o_tile_last, 0);
        check("arst_busy", busy, 0);
        check("arst_done", o_done, 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        rstn = 1'b1;
        check("arst_no_done", done_seen - d0, 0);
        run_cfg(16'h0100, 10, 12, 1, 1'b0, 1'b1, 1'b0, 256, 120);

        // Randomised configurations under random backpressure.
        for (int k = 0; k < 6; k++) begin
            rows = $urandom_range(1, 30);
            cols = $urandom_range(1, 30);
            run_cfg(16'($urandom), rows, cols, $urandom_range(0, 3), 1'b0, 1'b1, 1'b0, -1, 0);
        end

`ifdef WADDR_TRANSPOSE_EN
        run_cfg(16'h0100, 10, 12, 1, 1'b1, 1'b0, 1'b0, 256, 120);
        run_cfg(16'($urandom), 13, 19, 2, 1'b1, 1'b1, 1'b0, -1, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
